// File: rtl/alu_issue_ctrl.sv
// Three-state issue controller: IDLE accepts, ISSUE drives the ALU, WB retires; accept-to-done 2 cycles.
// Backpressure: instr_ready is high only in IDLE, so one instruction every 3 cycles; illegal opcodes pulse err.
module alu_issue_ctrl #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic        alu_enable,
  output logic [4:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        host_we,
  input  logic [2:0]  host_waddr,
  input  logic [15:0] host_wdata,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_s,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_ADC = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_INC = 5'd3;
  localparam logic [4:0] OP_DEC = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5;
  localparam logic [4:0] OP_OR  = 5'd6;
  localparam logic [4:0] OP_XOR = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_CMP = 5'd9;

  logic [1:0]  r_state;
  logic [13:0] r_instr;
  logic [15:0] r_regs [NREGS];
  logic        r_flag_c;
  logic        r_flag_z;
  logic        r_flag_s;
  logic        r_err;

  logic        w_accept;
  logic        w_legal;
  logic [4:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic        w_unary;
  logic        w_logic_op;
  logic        w_unused;

  assign w_unused = ^instr[1:0];

  assign w_op  = r_instr[13:9];
  assign w_rd  = r_instr[8:6];
  assign w_rs1 = r_instr[5:3];
  assign w_rs2 = r_instr[2:0];

  always_comb begin
    w_legal = 1'b0;
    case (instr[15:11])
      OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CMP: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_unary    = (w_op == OP_INC) || (w_op == OP_DEC) || (w_op == OP_NOT);
  assign w_logic_op = (w_op == OP_AND) || (w_op == OP_OR) || (w_op == OP_XOR) || (w_op == OP_NOT);

  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_valid && instr_ready;
  assign done        = (r_state == S_WB);
  assign err         = r_err;
  assign flag_c      = r_flag_c;
  assign flag_z      = r_flag_z;
  assign flag_s      = r_flag_s;
  assign dbg_data    = r_regs[dbg_addr];

  always_comb begin
    alu_enable = 1'b0;
    alu_opcode = 5'd0;
    alu_a      = 16'd0;
    alu_b      = 16'd0;
    if (r_state == S_ISSUE) begin
      alu_enable = 1'b1;
      alu_opcode = w_op;
      alu_a      = r_regs[w_rs1];
      alu_b      = w_unary ? 16'd0 : r_regs[w_rs2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= 14'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_legal) begin
            r_state <= S_ISSUE;
            r_instr <= instr[15:2];
          end
        end
        S_ISSUE: r_state <= S_WB;
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Host write goes first so a same-edge writeback to the same register overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 16'd0;
    end else begin
      if (host_we) r_regs[host_waddr] <= host_wdata;
      if ((r_state == S_WB) && (w_op != OP_CMP)) r_regs[w_rd] <= alu_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_s <= 1'b0;
    end else if (r_state == S_WB) begin
      r_flag_z <= alu_zero;
      r_flag_s <= alu_out[15];
      if (!w_logic_op) r_flag_c <= alu_carry;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning number of 16-bit architectural registers (fixed 8; 3-bit register fields).
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr  input  16  [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] ignored.
REQ-006 SHALL have port instr_ready  output  1  controller can accept an instruction.
REQ-007 SHALL have port alu_enable  output  1  ALU enable.
REQ-008 SHALL have port alu_opcode  output  5  ALU OPCODE.
REQ-009 SHALL have ports alu_a, alu_b  output  16 each  ALU in_a, in_b.
REQ-010 SHALL have port alu_out  input  16  ALU result (registered inside ALU).
REQ-011 SHALL have ports alu_carry, alu_zero  input  1 each  ALU CFlag, ZeroFlag.
REQ-012 SHALL have ports host_we  input  1, host_waddr  input  3, host_wdata  input  16  host register write.
REQ-013 SHALL have ports dbg_addr  input  3, dbg_data  output  16  combinational register read.
REQ-014 SHALL have ports flag_c, flag_z, flag_s  output  1 each  architectural flags.
REQ-015 SHALL have ports done  output  1  one-cycle completion pulse; err  output  1  one-cycle illegal-opcode pulse.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WB; transitions IDLE->ISSUE on instr_valid&&instr_ready with legal opcode, ISSUE->WB unconditionally, WB->IDLE unconditionally.
REQ-017 SHALL assert instr_ready only in IDLE; instruction accepted on posedge with instr_valid&&instr_ready and latched.
REQ-018 Legal opcodes SHALL be ADD, ADC, SUB, INC, DEC, AND, OR, XOR, NOT, CMP per the shared instruction-set definitions.
REQ-019 Illegal opcode accepted in IDLE SHALL pulse err for the following cycle, stay in IDLE, no alu_enable, no register or flag change.
REQ-020 In ISSUE SHALL drive alu_enable=1, alu_opcode=latched opcode, alu_a=R[rs1], alu_b=R[rs2]; for INC, DEC, NOT alu_b=0.
REQ-021 Outside ISSUE alu_enable, alu_opcode, alu_a, alu_b SHALL be 0.
REQ-022 In WB SHALL write alu_out to R[rd] at end of cycle, except CMP (no register write).
REQ-023 In WB SHALL latch flag_z=alu_zero, flag_s=alu_out[15]; flag_c=alu_carry for ADD, ADC, SUB, INC, DEC, CMP; flag_c unchanged for AND, OR, XOR, NOT.
REQ-024 SHALL pulse done for exactly the WB cycle; accept-to-done latency 2 cycles; throughput 1 instruction per 3 cycles.
REQ-025 Host write SHALL update R[host_waddr] on posedge in any state; same-cycle WB write to same register SHALL win.
REQ-026 Host write to a source register during ISSUE SHALL not affect the issued operands' next-cycle result (operands sampled by ALU at ISSUE edge).
REQ-027 dbg_data SHALL equal R[dbg_addr] combinationally, reflecting writes the cycle after the edge.
REQ-028 rd==rs1==rs2 SHALL be legal; old value used as operand, new value written.

Reset
REQ-029 rst high SHALL immediately force IDLE, all R[] to 0, flags 0, done/err/alu_enable/alu outputs 0, latched instruction 0.
REQ-030 rst asserted mid-ISSUE or mid-WB SHALL abort the instruction: no register write, no done pulse.
REQ-031 After rst deassert, instr_ready SHALL be 1 in the first cycle.

Verification
REQ-032 host R1=0x0003, R2=0x0005; ADD rd=3,rs1=1,rs2=2 -> ISSUE alu_a=3 alu_b=5; done 2 cycles after accept; R3=0x0008, flag_z=0, flag_c=0.
REQ-033 R1=0xFFFF, INC rd=1,rs1=1 -> R1=0x0000, flag_z=1, flag_c=1, flag_s=0; alu_b=0 during ISSUE.
REQ-034 R1=0x0004, R2=0x0004; CMP rs1=1,rs2=2 -> R registers unchanged, flag_z=1, done pulsed; then AND -> flag_c held.
REQ-035 Illegal opcode 5'b11111 -> err pulse one cycle, alu_enable never high, instr_ready high next cycle, registers unchanged.
REQ-036 rst asserted during ISSUE of ADD rd=3 -> R3=0, no done, IDLE with instr_ready=1 after deassert.
REQ-037 Host write R3=0x1234 same cycle as WB writing R3=0x0008 -> R3=0x0008.
